// File: rtl/sram_rw_port_arbiter.sv
// Shares one single-port masked SRAM (RW0_* macro interface) between a read and a write requester.
// Clears the array with a sweep after reset or flush, then round-robins contended accesses.
module sram_rw_port_arbiter #(
    parameter int                DEPTH    = 64,
    parameter int                ADDR_W   = 6,
    parameter int                DATA_W   = 6,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    output logic              init_busy,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_resp_valid,
    output logic [DATA_W-1:0] rd_resp_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              RW0_clk,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic              RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    // Handshake: a request is transferred in any cycle where valid and ready are both high;
    // ready is combinational from valid, state, flush and reset, and the requester may hold valid
    // until it sees ready. The read response has no backpressure and appears one cycle later.

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic              prefer_wr;
    logic              resp_pending;
    logic [DATA_W-1:0] resp_data_q;

    logic run_ok;
    logic grant_wr;
    logic grant_rd;

    assign run_ok   = (state == ST_RUN) && !flush && !reset;
    assign grant_wr = run_ok && wr_valid && (!rd_valid || prefer_wr);
    assign grant_rd = run_ok && rd_valid && (!wr_valid || !prefer_wr);

    assign rd_ready  = grant_rd;
    assign wr_ready  = grant_wr;
    assign init_busy = (state == ST_INIT);
    assign RW0_clk   = clock;
    assign RW0_wmask = 1'b1;

    // A read still in flight when reset arrives is dropped rather than reported.
    assign rd_resp_valid = resp_pending && !reset;
    assign rd_resp_data  = rd_resp_valid ? RW0_rdata : resp_data_q;

    always_comb begin
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_addr  = '0;
        RW0_wdata = '0;
        if (state == ST_INIT) begin
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
            RW0_addr  = init_cnt;
            RW0_wdata = INIT_VAL;
        end else if (grant_wr) begin
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
            RW0_addr  = wr_addr;
            RW0_wdata = wr_data;
        end else if (grant_rd) begin
            RW0_en    = 1'b1;
            RW0_addr  = rd_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_INIT;
            init_cnt     <= '0;
            prefer_wr    <= 1'b1;
            resp_pending <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            resp_pending <= grant_rd;
            if (resp_pending) begin
                resp_data_q <= RW0_rdata;
            end
            // Pointer moves only when both sides competed; it then names the loser.
            if (rd_valid && wr_valid && (grant_rd || grant_wr)) begin
                prefer_wr <= grant_rd;
            end
            case (state)
                ST_INIT: begin
                    if (flush) begin
                        init_cnt <= '0;
                    end else if (init_cnt == LAST_ADDR) begin
                        init_cnt <= '0;
                        state    <= ST_RUN;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        init_cnt <= '0;
                        state    <= ST_INIT;
                    end
                end
                default: begin
                    state    <= ST_INIT;
                    init_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// Directed bench for sram_rw_port_arbiter: behavioural SRAM model, vector table for RUN-mode
// traffic, and hand-written sequences for the sweep, flush and reset corner cases.
module tb_sram_rw_port_arbiter;

    logic       clock;
    logic       reset;
    logic       flush;
    logic       init_busy;
    logic       rd_valid;
    logic       rd_ready;
    logic [5:0] rd_addr;
    logic       rd_resp_valid;
    logic [5:0] rd_resp_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [5:0] wr_addr;
    logic [5:0] wr_data;
    logic       RW0_clk;
    logic [5:0] RW0_addr;
    logic       RW0_en;
    logic       RW0_wmode;
    logic       RW0_wmask;
    logic [5:0] RW0_wdata;
    logic [5:0] RW0_rdata;

    int n_cmp;
    int n_err;

    sram_rw_port_arbiter dut (
        .clock(clock), .reset(reset), .flush(flush), .init_busy(init_busy),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .RW0_clk(RW0_clk), .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
        .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
    );

    // Clock and SRAM macro model (one-cycle registered read, write at the edge)
    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [5:0] mem [64];
    initial begin
        RW0_rdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = 6'($urandom_range(1, 63));
    end
    always @(posedge RW0_clk) begin
        if (RW0_en) begin
            if (RW0_wmode) mem[RW0_addr] <= RW0_wdata;
            else           RW0_rdata     <= mem[RW0_addr];
        end
    end

    typedef struct {
        logic       rv;
        logic [5:0] ra;
        logic       wv;
        logic [5:0] wa;
        logic [5:0] wd;
        logic       fl;
        logic       e_rr;
        logic       e_wr;
        logic       e_en;
        logic       e_wm;
        logic [5:0] e_addr;
        logic [5:0] e_wd;
        logic       e_rsv;
        logic [5:0] e_rsd;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(input int rv, input int ra, input int wv, input int wa,
                                input int wd, input int fl, input int err, input int ewr,
                                input int een, input int ewm, input int ea, input int ewd,
                                input int ersv, input int ersd);
        vec_t v;
        v.rv = rv[0];     v.ra = ra[5:0];   v.wv = wv[0];     v.wa = wa[5:0];
        v.wd = wd[5:0];   v.fl = fl[0];     v.e_rr = err[0];  v.e_wr = ewr[0];
        v.e_en = een[0];  v.e_wm = ewm[0];  v.e_addr = ea[5:0];
        v.e_wd = ewd[5:0]; v.e_rsv = ersv[0]; v.e_rsd = ersd[5:0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Driver: inputs set just after the edge, outputs checked at the falling edge.
    task automatic apply(input int idx);
        vec_t v;
        v = tbl[idx];
        rd_valid = v.rv; rd_addr = v.ra; wr_valid = v.wv; wr_addr = v.wa;
        wr_data = v.wd;  flush = v.fl;
        #4;
        chk($sformatf("v%0d init_busy", idx), 8'(init_busy), 8'd0);
        chk($sformatf("v%0d rd_ready", idx), 8'(rd_ready), 8'(v.e_rr));
        chk($sformatf("v%0d wr_ready", idx), 8'(wr_ready), 8'(v.e_wr));
        chk($sformatf("v%0d RW0_en", idx), 8'(RW0_en), 8'(v.e_en));
        if (v.e_en) begin
            chk($sformatf("v%0d RW0_wmode", idx), 8'(RW0_wmode), 8'(v.e_wm));
            chk($sformatf("v%0d RW0_addr", idx), 8'(RW0_addr), 8'(v.e_addr));
            if (v.e_wm) chk($sformatf("v%0d RW0_wdata", idx), 8'(RW0_wdata), 8'(v.e_wd));
        end
        chk($sformatf("v%0d rd_resp_valid", idx), 8'(rd_resp_valid), 8'(v.e_rsv));
        chk($sformatf("v%0d rd_resp_data", idx), 8'(rd_resp_data), 8'(v.e_rsd));
        @(posedge clock); #1;
    endtask

    task automatic sweep_check(input int n, input int start, input logic hold);
        for (int i = 0; i < n; i++) begin
            rd_valid = hold; rd_addr = 6'd63; wr_valid = hold; wr_addr = 6'd1;
            wr_data = 6'h15; flush = 1'b0;
            #4;
            chk($sformatf("sweep%0d init_busy", start + i), 8'(init_busy), 8'd1);
            chk($sformatf("sweep%0d RW0_en", start + i), 8'(RW0_en), 8'd1);
            chk($sformatf("sweep%0d RW0_wmode", start + i), 8'(RW0_wmode), 8'd1);
            chk($sformatf("sweep%0d RW0_addr", start + i), 8'(RW0_addr), 8'(start + i));
            chk($sformatf("sweep%0d RW0_wdata", start + i), 8'(RW0_wdata), 8'd0);
            chk($sformatf("sweep%0d rd_ready", start + i), 8'(rd_ready), 8'd0);
            chk($sformatf("sweep%0d wr_ready", start + i), 8'(wr_ready), 8'd0);
            chk($sformatf("sweep%0d rd_resp_valid", start + i), 8'(rd_resp_valid), 8'd0);
            @(posedge clock); #1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        //           rv ra  wv wa wd    fl  rr wr en wm addr wd    rsv rsd
        tbl[0]  = mk(0, 0,  0, 0, 0,    0,  0, 0, 0, 0, 0,  0,    0, 0);
        tbl[1]  = mk(0, 0,  1, 5, 'h2A, 0,  0, 1, 1, 1, 5,  'h2A, 0, 0);
        tbl[2]  = mk(1, 5,  0, 0, 0,    0,  1, 0, 1, 0, 5,  0,    0, 0);
        tbl[3]  = mk(1, 9,  0, 0, 0,    0,  1, 0, 1, 0, 9,  0,    1, 'h2A);
        tbl[4]  = mk(0, 0,  0, 0, 0,    0,  0, 0, 0, 0, 0,  0,    1, 0);
        tbl[5]  = mk(1, 5,  1, 7, 'h15, 0,  0, 1, 1, 1, 7,  'h15, 0, 0);
        tbl[6]  = mk(1, 5,  1, 8, 'h16, 0,  1, 0, 1, 0, 5,  0,    0, 0);
        tbl[7]  = mk(1, 7,  1, 8, 'h16, 0,  0, 1, 1, 1, 8,  'h16, 1, 'h2A);
        tbl[8]  = mk(1, 7,  1, 10, 1,   0,  1, 0, 1, 0, 7,  0,    0, 'h2A);
        tbl[9]  = mk(0, 0,  1, 10, 1,   0,  0, 1, 1, 1, 10, 1,    1, 'h15);
        tbl[10] = mk(1, 8,  0, 0, 0,    0,  1, 0, 1, 0, 8,  0,    0, 'h15);
        tbl[11] = mk(1, 10, 0, 0, 0,    0,  1, 0, 1, 0, 10, 0,    1, 'h16);
        tbl[12] = mk(1, 10, 0, 0, 0,    0,  1, 0, 1, 0, 10, 0,    1, 1);
        tbl[13] = mk(0, 0,  1, 10, 'h22, 0, 0, 1, 1, 1, 10, 'h22, 1, 1);
        tbl[14] = mk(0, 0,  0, 0, 0,    0,  0, 0, 0, 0, 0,  0,    0, 1);
        tbl[15] = mk(0, 0,  1, 63, 'h3F, 0, 0, 1, 1, 1, 63, 'h3F, 0, 1);
        tbl[16] = mk(1, 3,  1, 3, 'h11, 0,  0, 1, 1, 1, 3,  'h11, 0, 1);
        tbl[17] = mk(1, 3,  0, 0, 0,    0,  1, 0, 1, 0, 3,  0,    0, 1);
        tbl[18] = mk(1, 63, 1, 4, 7,    1,  0, 0, 0, 0, 0,  0,    1, 'h11);
        tbl[19] = mk(0, 0,  0, 0, 0,    0,  0, 0, 0, 0, 0,  0,    0, 'h11);
        tbl[20] = mk(1, 63, 0, 0, 0,    0,  1, 0, 1, 0, 63, 0,    0, 'h11);
        tbl[21] = mk(0, 0,  1, 3, 'h2C, 0,  0, 1, 1, 1, 3,  'h2C, 1, 0);
        tbl[22] = mk(1, 3,  0, 0, 0,    0,  1, 0, 1, 0, 3,  0,    0, 0);
        tbl[23] = mk(0, 0,  0, 0, 0,    0,  0, 0, 0, 0, 0,  0,    0, 0);
        tbl[24] = mk(1, 3,  0, 0, 0,    0,  1, 0, 1, 0, 3,  0,    0, 0);
        tbl[25] = mk(0, 0,  0, 0, 0,    0,  0, 0, 0, 0, 0,  0,    1, 0);

        // Reset with both requests held: nothing may be accepted
        reset = 1'b1; flush = 1'b0; rd_valid = 1'b1; wr_valid = 1'b1;
        rd_addr = 6'd2; wr_addr = 6'd2; wr_data = 6'h3;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            #4;
            chk("reset init_busy", 8'(init_busy), 8'd1);
            chk("reset rd_ready", 8'(rd_ready), 8'd0);
            chk("reset wr_ready", 8'(wr_ready), 8'd0);
            chk("reset rd_resp_valid", 8'(rd_resp_valid), 8'd0);
            chk("reset rd_resp_data", 8'(rd_resp_data), 8'd0);
        end
        @(posedge clock); #1;
        reset = 1'b0;

        // Initial sweep: exactly 64 clear writes, then RUN traffic
        sweep_check(64, 0, 1'b0);
        for (int i = 0; i <= 18; i++) apply(i);

        // Flush issued in tbl[18]; sweep runs with both requesters waiting
        sweep_check(64, 0, 1'b1);
        for (int i = 19; i <= 22; i++) apply(i);

        // Reset while the read of addr 3 is in flight: its response is dropped
        reset = 1'b1; rd_valid = 1'b1; rd_addr = 6'd4; wr_valid = 1'b0; flush = 1'b0;
        #4;
        chk("inflight rd_resp_valid", 8'(rd_resp_valid), 8'd0);
        chk("inflight rd_resp_data", 8'(rd_resp_data), 8'd0);
        chk("inflight rd_ready", 8'(rd_ready), 8'd0);
        chk("inflight RW0_en", 8'(RW0_en), 8'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Reset again at sweep counter 30: the sweep restarts from 0 and runs in full
        sweep_check(30, 0, 1'b0);
        reset = 1'b1; rd_valid = 1'b0;
        #4;
        chk("midsweep RW0_addr", 8'(RW0_addr), 8'd30);
        chk("midsweep init_busy", 8'(init_busy), 8'd1);
        chk("midsweep rd_resp_valid", 8'(rd_resp_valid), 8'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        sweep_check(64, 0, 1'b0);
        for (int i = 23; i <= 25; i++) apply(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
